// File: rtl/aes_decryption_iter.sv
// Iterative AES-256 decryptor: one inverse round per clock over a single 128-bit state register.
// Optional completed-block counter output is enabled with macro AES_DEC_BLK_CNT_EN.
`timescale 1ns/1ps
module aes_decryption_iter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [127:0]         ciphertext_i,
    input  logic [255:0]         key_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
`ifdef AES_DEC_BLK_CNT_EN
    output logic [CNT_WIDTH-1:0] blocks_done_o,
`endif
    output logic [127:0]         plaintext_o
);

    // state | meaning
    // IDLE  | waiting for a ciphertext/key handshake
    // INIT  | initial AddRoundKey with rk[14]
    // ROUND | inverse rounds 13..1, one per clock
    // FINAL | last inverse round (no InvMixColumns) with rk[0]
    // DONE  | plaintext presented until consumer accepts
    typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} fsm_t;

    fsm_t           fsm_q, fsm_d;
    logic [127:0]   blk_q, blk_d;
    logic [255:0]   key_q, key_d;
    logic [3:0]     rnd_q, rnd_d;
    logic [127:0]   pt_q, pt_d;

    logic [1919:0]  round_keys;
    logic [127:0]   rk_cur, rk_first, rk_last;
    logic [127:0]   isb_out, round_out, final_out;

    if (CNT_WIDTH < 1) begin : g_cnt_width_bad
        $error("CNT_WIDTH must be at least 1");
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ ({8{x[7]}} & 8'h1b);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t;
        t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [1919:0] expand_key(input logic [255:0] k);
        logic [1919:0] rk;
        logic [31:0]   t;
        logic [7:0]    rcon;
        rk   = '0;
        rcon = 8'h01;
        for (int i = 0; i < 8; i++) rk[1919-32*i -: 32] = k[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = rk[1919-32*(i-1) -: 32];
            if (i % 8 == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
                rcon = {rcon[6:0], 1'b0};
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            rk[1919-32*i -: 32] = rk[1919-32*(i-8) -: 32] ^ t;
        end
        return rk;
    endfunction

    // byte b of the block sits at [127-8b -: 8]; row r, column c is byte r+4c
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int b = 0; b < 16; b++) o[127-8*b -: 8] = inv_sbox(s[127-8*b -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    assign round_keys = expand_key(key_q);
    assign rk_first   = round_keys[1919:1792];
    assign rk_last    = round_keys[127:0];
    assign rk_cur     = round_keys[11'd1919 - {rnd_q, 7'd0} -: 128];

    assign isb_out    = inv_sub_bytes(inv_shift_rows(blk_q));
    assign round_out  = inv_mix_columns(isb_out ^ rk_cur);
    assign final_out  = isb_out ^ rk_first;

    always_comb begin
        fsm_d = fsm_q;
        blk_d = blk_q;
        key_d = key_q;
        rnd_d = rnd_q;
        pt_d  = pt_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid_i) begin
                    blk_d = ciphertext_i;
                    key_d = key_i;
                    fsm_d = INIT;
                end
            end
            INIT: begin
                blk_d = blk_q ^ rk_last;
                rnd_d = 4'd13;
                fsm_d = ROUND;
            end
            ROUND: begin
                blk_d = round_out;
                rnd_d = rnd_q - 4'd1;
                if (rnd_q == 4'd1) fsm_d = FINAL;
            end
            FINAL: begin
                pt_d  = final_out;
                fsm_d = DONE;
            end
            DONE: begin
                if (out_ready_i) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fsm_q <= IDLE;
            blk_q <= '0;
            key_q <= '0;
            rnd_q <= '0;
            pt_q  <= '0;
        end else begin
            fsm_q <= fsm_d;
            blk_q <= blk_d;
            key_q <= key_d;
            rnd_q <= rnd_d;
            pt_q  <= pt_d;
        end
    end

    assign in_ready_o  = (fsm_q == IDLE);
    assign out_valid_o = (fsm_q == DONE);
    assign plaintext_o = pt_q;

`ifdef AES_DEC_BLK_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) cnt_q <= '0;
        else if (out_valid_o && out_ready_i) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end

    assign blocks_done_o = cnt_q;
`endif

endmodule

// File: tb/tb_aes_decryption_iter.sv
// Directed-vector bench for aes_decryption_iter: FIPS-197 C.3 and SP800-38A ECB-AES256 vectors,
// backpressure, busy-input scrambling, mid-round reset and back-to-back blocks.
`timescale 1ns/1ps
module tb_aes_decryption_iter;

    localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_C3   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY_ECB = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] CT_E1   = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
    localparam logic [127:0] PT_E1   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT_E2   = 128'h591ccb10d410ed26dc5ba74a31362870;
    localparam logic [127:0] PT_E2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CT_E3   = 128'hb6ed21b99ca6f4f9f153e7b1beafed1d;
    localparam logic [127:0] PT_E3   = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] CT_E4   = 128'h23304b7a39f9f3ff067d8d8f9e24ecc7;
    localparam logic [127:0] PT_E4   = 128'hf69f2445df4f9b17ad2b417be66c3710;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [127:0] ciphertext_i;
    logic [255:0] key_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [127:0] plaintext_o;
`ifdef AES_DEC_BLK_CNT_EN
    logic [31:0]  blocks_done_o;
`endif

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;

    always #5 clk_i = ~clk_i;

    aes_decryption_iter #(.CNT_WIDTH(32)) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .ciphertext_i (ciphertext_i),
        .key_i        (key_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
`ifdef AES_DEC_BLK_CNT_EN
        .blocks_done_o(blocks_done_o),
`endif
        .plaintext_o  (plaintext_o)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge that follows the
    // output handshake, with in_valid_i still asserted so the caller decides what comes next.
    task automatic run_blk(input string tag, input logic [255:0] key, input logic [127:0] ct,
                           input logic [127:0] exp_pt, input int hold, input bit busy);
        int n;
        bit rdy_seen;
        in_valid_i   = 1'b1;
        key_i        = key;
        ciphertext_i = ct;
        out_ready_i  = (hold == 0);
        n = 0;
        while (!in_ready_o && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        chk({tag, "_acc_rdy"}, in_ready_o, 1'b1);
        @(posedge clk_i);
        n = 0;
        rdy_seen = 1'b0;
        while (1) begin
            if (busy) begin
                #1;
                ciphertext_i = {$urandom, $urandom, $urandom, $urandom};
                key_i        = {$urandom, $urandom, $urandom, $urandom,
                                $urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk_i);
            if (in_ready_o) rdy_seen = 1'b1;
            if (out_valid_o || n >= 40) break;
            @(posedge clk_i);
            n++;
        end
        chk({tag, "_latency"}, n, 15);
        chk({tag, "_pt"}, plaintext_o, exp_pt);
        chk({tag, "_busy_rdy"}, rdy_seen, 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            chk({tag, "_hold_pt"}, plaintext_o, exp_pt);
            chk({tag, "_hold_vld"}, out_valid_o, 1'b1);
            chk({tag, "_hold_rdy"}, in_ready_o, 1'b0);
        end
        out_ready_i = 1'b1;
        @(posedge clk_i);
        exp_cnt++;
        @(negedge clk_i);
        chk({tag, "_post_vld"}, out_valid_o, 1'b0);
        chk({tag, "_post_rdy"}, in_ready_o, 1'b1);
    endtask

    initial begin
        reset_n_i    = 1'b0;
        in_valid_i   = 1'b0;
        out_ready_i  = 1'b0;
        ciphertext_i = '0;
        key_i        = '0;
        #12;
        chk("rst_rdy", in_ready_o, 1'b1);
        chk("rst_vld", out_valid_o, 1'b0);
        chk("rst_pt", plaintext_o, 128'h0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);

        run_blk("c3", KEY_C3, CT_C3, PT_C3, 0, 1'b0);
        in_valid_i = 1'b0;
        @(negedge clk_i);

        run_blk("bp", KEY_ECB, CT_E1, PT_E1, 10, 1'b0);
        in_valid_i = 1'b0;
        @(negedge clk_i);

        run_blk("busy", KEY_ECB, CT_E2, PT_E2, 0, 1'b1);
        in_valid_i = 1'b0;
        @(negedge clk_i);

        // accept a block, then pull reset while the round counter sits at 7
        in_valid_i   = 1'b1;
        key_i        = KEY_ECB;
        ciphertext_i = CT_E3;
        @(posedge clk_i);
        #1 in_valid_i = 1'b0;
        repeat (7) @(posedge clk_i);
        #3 reset_n_i = 1'b0;
        #1;
        exp_cnt = 0;
        chk("midrst_pt", plaintext_o, 128'h0);
        chk("midrst_vld", out_valid_o, 1'b0);
        chk("midrst_rdy", in_ready_o, 1'b1);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        chk("midrst_rel_vld", out_valid_o, 1'b0);
        chk("midrst_rel_rdy", in_ready_o, 1'b1);
        run_blk("after_rst", KEY_ECB, CT_E3, PT_E3, 0, 1'b0);
        in_valid_i = 1'b0;
        @(negedge clk_i);

        run_blk("b2b0", KEY_C3, CT_C3, PT_C3, 0, 1'b0);
        run_blk("b2b1", KEY_ECB, CT_E4, PT_E4, 0, 1'b0);
        run_blk("b2b2", KEY_ECB, CT_E1, PT_E1, 0, 1'b0);
        in_valid_i = 1'b0;
        @(negedge clk_i);
`ifdef AES_DEC_BLK_CNT_EN
        chk("blocks_done", blocks_done_o, exp_cnt);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
